// File: rtl/pd_pkg.sv
// pd_pkg: state and vote encodings shared by the phase-detector vote filter.
package pd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2
    } pd_state_e;

    typedef enum logic [1:0] {
        V_NONE = 2'd0,
        V_LEAD = 2'd1,
        V_LAG  = 2'd2
    } pd_vote_e;

    // Majority decision over nch channels, given how many channels report "lead".
    function automatic pd_vote_e majority_vote(input int ones, input int nch);
        if (2 * ones > nch) begin
            return V_LEAD;
        end else if (2 * ones < nch) begin
            return V_LAG;
        end else begin
            return V_NONE;
        end
    endfunction

endpackage

// File: rtl/pd_sync2.sv
// pd_sync2: two-flop synchroniser for one asynchronous phase-detector level.
module pd_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    // Next-state: shift the raw level through two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // First stage may go metastable; the second gives it a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values, so the two stages really form a pipeline.
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pd_vote_filter.sv
// pd_vote_filter: synchronise NCH bang-bang detector levels, majority-vote them,
// filter the votes in a random-walk counter and step a saturating control word.
// Lock detection switches between coarse (acquire) and fine (track) stepping.
module pd_vote_filter
    import pd_pkg::*;
#(
    parameter int NCH        = 3,
    parameter int CW_W       = 8,
    parameter int CW_INIT    = 128,
    parameter int RW_TH      = 4,
    parameter int STEP_ACQ   = 4,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_RUN = 8
) (
    input  logic            ref_clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic [NCH-1:0]  lead_lag,
    output logic [CW_W-1:0] ctrl_word,
    output logic            step_up,
    output logic            step_dn,
    output logic            locked,
    output logic [1:0]      state
);

    localparam int RW_W  = $clog2(RW_TH + 1) + 1;
    localparam int REV_W = $clog2(LOCK_CNT + 1);
    localparam int RUN_W = $clog2(UNLOCK_RUN + 1);

    localparam logic signed [RW_W-1:0] RW_POS  = RW_W'(RW_TH);
    localparam logic signed [RW_W-1:0] RW_NEG  = RW_W'(-RW_TH);
    localparam logic signed [RW_W-1:0] RW_ONE  = RW_W'(1);
    localparam logic [REV_W-1:0]       REV_MAX = REV_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0]       RUN_MAX = RUN_W'(UNLOCK_RUN);

    logic [NCH-1:0] ll_sync;
    pd_vote_e       vote;

    pd_state_e               state_d,    state_q;
    logic signed [RW_W-1:0]  rw_d,       rw_q;
    logic [CW_W-1:0]         cw_d,       cw_q;
    logic                    up_d,       up_q;
    logic                    dn_d,       dn_q;
    logic                    locked_d,   locked_q;
    logic [REV_W-1:0]        rev_d,      rev_q;
    logic [RUN_W-1:0]        run_d,      run_q;
    logic                    have_dir_d, have_dir_q;   // a step has been taken since IDLE
    logic                    last_up_d,  last_up_q;    // direction of that most recent step

    logic signed [RW_W-1:0]  rw_nxt;
    logic [CW_W-1:0]         step_sz;
    logic [CW_W:0]           cw_sum;

    for (genvar i = 0; i < NCH; i++) begin : g_sync
        pd_sync2 u_sync (
            .clk   (ref_clk),
            .rst_n (reset_n),
            .d     (lead_lag[i]),
            .q     (ll_sync[i])
        );
    end

    assign vote = majority_vote($countones(ll_sync), NCH);

    // Next-state for the walk counter, control word, lock counters and FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        state_d    = state_q;
        rw_d       = rw_q;
        cw_d       = cw_q;
        up_d       = 1'b0;
        dn_d       = 1'b0;
        locked_d   = locked_q;
        rev_d      = rev_q;
        run_d      = run_q;
        have_dir_d = have_dir_q;
        last_up_d  = last_up_q;
        rw_nxt     = rw_q;
        // Size follows the current state, so the lock-causing step is still coarse.
        step_sz    = (state_q == ST_ACQ) ? CW_W'(STEP_ACQ) : CW_W'(1);
        cw_sum     = {1'b0, cw_q} + {1'b0, step_sz};

        if (!enable) begin
            // Leaving the loop keeps ctrl_word so re-enabling resumes from the same point.
            state_d    = ST_IDLE;
            rw_d       = '0;
            rev_d      = '0;
            run_d      = '0;
            have_dir_d = 1'b0;
            locked_d   = 1'b0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_ACQ;
        end else begin
            case (vote)
                V_LAG:   rw_nxt = rw_q + RW_ONE;
                V_LEAD:  rw_nxt = rw_q - RW_ONE;
                default: rw_nxt = rw_q;
            endcase
            rw_d = rw_nxt;

            if (rw_nxt == RW_POS) begin
                up_d = 1'b1;
                rw_d = '0;
                cw_d = cw_sum[CW_W] ? '1 : cw_sum[CW_W-1:0];
            end else if (rw_nxt == RW_NEG) begin
                dn_d = 1'b1;
                rw_d = '0;
                cw_d = (cw_q < step_sz) ? '0 : cw_q - step_sz;
            end

            if (up_d || dn_d) begin
                if (!have_dir_q) begin
                    rev_d = '0;
                    run_d = RUN_W'(1);
                end else if (up_d != last_up_q) begin
                    rev_d = (rev_q == REV_MAX) ? rev_q : rev_q + REV_W'(1);
                    run_d = RUN_W'(1);
                end else begin
                    rev_d = '0;
                    run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
                end
                have_dir_d = 1'b1;
                last_up_d  = up_d;

                if (state_q == ST_ACQ && rev_d == REV_MAX) begin
                    state_d  = ST_TRACK;
                    locked_d = 1'b1;
                end else if (state_q == ST_TRACK && run_d == RUN_MAX) begin
                    state_d  = ST_ACQ;
                    locked_d = 1'b0;
                    rev_d    = '0;
                end
            end
        end
    end

    // All filter state and registered outputs.
    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rw_q       <= '0;
            cw_q       <= CW_W'(CW_INIT);
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
            locked_q   <= 1'b0;
            rev_q      <= '0;
            run_q      <= '0;
            have_dir_q <= 1'b0;
            last_up_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            cw_q       <= cw_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
            locked_q   <= locked_d;
            rev_q      <= rev_d;
            run_q      <= run_d;
            have_dir_q <= have_dir_d;
            last_up_q  <= last_up_d;
        end
    end

    assign ctrl_word = cw_q;
    assign step_up   = up_q;
    assign step_dn   = dn_q;
    assign locked    = locked_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pd_vote_filter.sv
// tb_pd_vote_filter: randomized and directed stimulus for pd_vote_filter,
// compared each cycle against a rule-level reference model.
module tb_pd_vote_filter;

    localparam logic [12:0] RESET_VEC = {8'd128, 1'b0, 1'b0, 1'b0, 2'd0};

    logic       ref_clk;
    logic       reset_n;
    logic       enable;
    logic [2:0] lead_lag;
    logic [7:0] ctrl_word;
    logic       step_up, step_dn, locked;
    logic [1:0] state;

    logic       enable4;
    logic [3:0] lead_lag4;
    logic [7:0] ctrl_word4;
    logic       step_up4, step_dn4, locked4;
    logic [1:0] state4;

    logic [12:0] dut_vec;
    assign dut_vec = {ctrl_word, step_up, step_dn, locked, state};

    int errors = 0;
    int checks = 0;

    pd_vote_filter #(.NCH(3)) u_dut (
        .ref_clk   (ref_clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .lead_lag  (lead_lag),
        .ctrl_word (ctrl_word),
        .step_up   (step_up),
        .step_dn   (step_dn),
        .locked    (locked),
        .state     (state)
    );

    pd_vote_filter #(.NCH(4)) u_dut4 (
        .ref_clk   (ref_clk),
        .reset_n   (reset_n),
        .enable    (enable4),
        .lead_lag  (lead_lag4),
        .ctrl_word (ctrl_word4),
        .step_up   (step_up4),
        .step_dn   (step_dn4),
        .locked    (locked4),
        .state     (state4)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    // ---------------- reference model (NCH=3, default parameters) ----------------
    int         m_state, m_rw, m_cw, m_dir, m_rev, m_run;
    bit         m_locked, m_up, m_dn;
    logic [2:0] m_s1, m_s2;

    task automatic model_reset();
        m_state = 0; m_rw = 0; m_cw = 128; m_dir = 0; m_rev = 0; m_run = 0;
        m_locked = 0; m_up = 0; m_dn = 0; m_s1 = '0; m_s2 = '0;
    endtask

    // One rising edge: vote on the level seen two edges ago, apply the filter rules.
    task automatic model_edge(input logic en, input logic [2:0] ll);
        int ones, vote, nrw, dir;
        ones = $countones(m_s2);
        vote = (2 * ones > 3) ? -1 : ((2 * ones < 3) ? 1 : 0);
        m_up = 0;
        m_dn = 0;
        if (!en) begin
            m_state = 0; m_rw = 0; m_rev = 0; m_run = 0; m_dir = 0; m_locked = 0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else begin
            dir = 0;
            nrw = m_rw + vote;
            if (nrw == 4)       dir = 1;
            else if (nrw == -4) dir = -1;
            m_rw = (dir != 0) ? 0 : nrw;
            if (dir != 0) begin
                m_cw = m_cw + dir * ((m_state == 1) ? 4 : 1);
                if (m_cw > 255) m_cw = 255;
                if (m_cw < 0)   m_cw = 0;
                m_up = (dir == 1);
                m_dn = (dir == -1);
                if (m_dir == 0) begin
                    m_rev = 0; m_run = 1;
                end else if (dir != m_dir) begin
                    m_rev = (m_rev < 4) ? m_rev + 1 : 4; m_run = 1;
                end else begin
                    m_rev = 0; m_run = (m_run < 8) ? m_run + 1 : 8;
                end
                m_dir = dir;
                if (m_state == 1 && m_rev == 4) begin
                    m_state = 2; m_locked = 1;
                end else if (m_state == 2 && m_run == 8) begin
                    m_state = 1; m_locked = 0; m_rev = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = ll;
    endtask

    function automatic logic [12:0] model_vec();
        return {8'(m_cw), m_up, m_dn, m_locked, 2'(m_state)};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick(input logic en, input logic [2:0] ll);
        enable   = en;
        lead_lag = ll;
        @(posedge ref_clk);
        model_edge(en, ll);
        @(negedge ref_clk);
    endtask

    task automatic apply_reset(input logic [2:0] ll);
        enable   = 1'b0;
        lead_lag = ll;
        reset_n  = 1'b0;
        model_reset();
        @(negedge ref_clk);
        reset_n = 1'b1;
    endtask

    function automatic logic [2:0] lock_ll(input int c);
        logic [2:0] v;
        v = (((c + 1) >> 2) & 1) != 0 ? 3'b111 : 3'b000;
        return v;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n   = 1'b0;
        enable4   = 1'b0;
        lead_lag4 = '0;
        for (int i = 0; i < 4; i++) begin
            lead_lag = 3'($urandom);
            enable   = 1'($urandom);
            @(negedge ref_clk);
            checks++;
            if (dut_vec !== RESET_VEC) begin
                errors++;
                $display("FAIL reset_hold: got %h expected %h", dut_vec, RESET_VEC);
            end
        end
        model_reset();
        enable = 1'b0;
        reset_n = 1'b1;
        tick(1'b0, 3'($urandom));
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", dut_vec, RESET_VEC);
        end
    endtask

    task automatic test_ramp_up();
        int exp_cw = 128;
        int since  = 0;
        int n_up   = 0;
        int sat    = 0;
        for (int t = 0; t < 200 && sat < 3; t++) begin
            tick(1'b1, 3'b000);
            since++;
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL ramp_up_model: got %h expected %h", dut_vec, model_vec());
            end
            if (step_up) begin
                exp_cw = (exp_cw + 4 > 255) ? 255 : exp_cw + 4;
                checks++;
                if (ctrl_word !== 8'(exp_cw)) begin
                    errors++;
                    $display("FAIL ramp_up_value: got %0d expected %0d", ctrl_word, exp_cw);
                end
                if (n_up > 0) begin
                    checks++;
                    if (since != 4) begin
                        errors++;
                        $display("FAIL ramp_up_interval: got %0d expected 4", since);
                    end
                end
                n_up++;
                since = 0;
                if (exp_cw == 255) sat++;
            end
        end
        checks++;
        if (sat < 3) begin
            errors++;
            $display("FAIL ramp_up_saturate: saturated pulses %0d expected 3", sat);
        end
    endtask

    task automatic test_ramp_down();
        int exp_cw = 255;
        int since  = 0;
        int n_dn   = 0;
        int sat    = 0;
        for (int t = 0; t < 320 && sat < 3; t++) begin
            tick(1'b1, 3'b111);
            since++;
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL ramp_dn_model: got %h expected %h", dut_vec, model_vec());
            end
            if (step_dn) begin
                exp_cw = (exp_cw - 4 < 0) ? 0 : exp_cw - 4;
                checks++;
                if (ctrl_word !== 8'(exp_cw)) begin
                    errors++;
                    $display("FAIL ramp_dn_value: got %0d expected %0d", ctrl_word, exp_cw);
                end
                if (n_dn > 0) begin
                    checks++;
                    if (since != 4) begin
                        errors++;
                        $display("FAIL ramp_dn_interval: got %0d expected 4", since);
                    end
                end
                n_dn++;
                since = 0;
                if (exp_cw == 0) sat++;
            end
        end
        checks++;
        if (sat < 3) begin
            errors++;
            $display("FAIL ramp_dn_saturate: saturated pulses %0d expected 3", sat);
        end
    endtask

    task automatic test_lead();
        int n_dn = 0;
        apply_reset(3'b011);
        for (int i = 0; i < 3; i++) tick(1'b0, 3'b011);
        for (int t = 0; t < 14; t++) begin
            tick(1'b1, 3'b011);
            if (step_dn) n_dn++;
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL lead_model: got %h expected %h", dut_vec, model_vec());
            end
        end
        checks++;
        if (ctrl_word !== 8'd116 || n_dn != 3) begin
            errors++;
            $display("FAIL lead_steps: got cw=%0d dn=%0d expected cw=116 dn=3", ctrl_word, n_dn);
        end
    endtask

    task automatic test_lock_track();
        apply_reset(3'b000);
        for (int i = 0; i < 3; i++) tick(1'b0, 3'b000);
        for (int c = 0; c < 28; c++) begin
            tick(1'b1, lock_ll(c));
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL lock_model: got %h expected %h", dut_vec, model_vec());
            end
        end
        checks++;
        if (state !== 2'd2 || locked !== 1'b1 || ctrl_word !== 8'd131) begin
            errors++;
            $display("FAIL lock_entry: got st=%0d lk=%b cw=%0d expected st=2 lk=1 cw=131",
                     state, locked, ctrl_word);
        end
        for (int c = 28; c < 68; c++) begin
            tick(1'b1, 3'b000);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL unlock_model: got %h expected %h", dut_vec, model_vec());
            end
        end
        checks++;
        if (state !== 2'd1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL unlock: got st=%0d lk=%b expected st=1 lk=0", state, locked);
        end
    endtask

    task automatic test_disable();
        int seen  = 0;
        int first = 0;
        int hold;
        for (int t = 0; t < 8 && seen == 0; t++) begin
            tick(1'b1, 3'b000);
            if (step_up) seen = 1;
        end
        checks++;
        if (seen == 0) begin
            errors++;
            $display("FAIL disable_prep: no step_up within 8 cycles");
        end
        for (int t = 0; t < 3; t++) tick(1'b1, 3'b000);    // walk counter now at 3
        hold = m_cw;
        for (int t = 0; t < 4; t++) begin
            tick(1'b0, 3'b000);
            checks++;
            if (state !== 2'd0 || locked !== 1'b0 || step_up !== 1'b0 || ctrl_word !== 8'(hold)) begin
                errors++;
                $display("FAIL disable_hold: got st=%0d lk=%b up=%b cw=%0d expected st=0 lk=0 up=0 cw=%0d",
                         state, locked, step_up, ctrl_word, hold);
            end
        end
        for (int t = 1; t <= 8 && first == 0; t++) begin
            tick(1'b1, 3'b000);
            if (step_up) first = t;
        end
        checks++;
        if (first != 5) begin
            errors++;
            $display("FAIL reenable_latency: got %0d expected 5", first);
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL reenable_model: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_reset_mid_track();
        apply_reset(3'b000);
        for (int i = 0; i < 3; i++) tick(1'b0, 3'b000);
        for (int c = 0; c < 24; c++) tick(1'b1, lock_ll(c));
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL midtrack_prep: got st=%0d expected 2", state);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", dut_vec, RESET_VEC);
        end
        model_reset();
        @(negedge ref_clk);
        reset_n = 1'b1;
    endtask

    task automatic test_nch4();
        int first = 0;
        enable    = 1'b0;
        enable4   = 1'b0;
        lead_lag4 = 4'b0011;
        repeat (3) @(negedge ref_clk);
        enable4 = 1'b1;
        for (int t = 0; t < 24; t++) begin
            @(negedge ref_clk);
            checks++;
            if (ctrl_word4 !== 8'd128 || step_up4 !== 1'b0 || step_dn4 !== 1'b0) begin
                errors++;
                $display("FAIL nch4_tie: got cw=%0d up=%b dn=%b expected cw=128 up=0 dn=0",
                         ctrl_word4, step_up4, step_dn4);
            end
        end
        checks++;
        if (state4 !== 2'd1) begin
            errors++;
            $display("FAIL nch4_state: got %0d expected 1", state4);
        end
        lead_lag4 = 4'b0001;
        for (int t = 1; t <= 10 && first == 0; t++) begin
            @(negedge ref_clk);
            if (step_up4) first = t;
        end
        checks++;
        if (first != 6 || ctrl_word4 !== 8'd132) begin
            errors++;
            $display("FAIL nch4_lag: got latency=%0d cw=%0d expected latency=6 cw=132", first, ctrl_word4);
        end
        enable4 = 1'b0;
    endtask

    task automatic test_random();
        int t = 0;
        apply_reset(3'($urandom));
        while (t < 400) begin
            logic [2:0] ll;
            logic       en;
            int         len;
            ll  = 3'($urandom);
            en  = ($urandom_range(0, 15) != 0);
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                tick(en, ll);
                t++;
                checks++;
                if (dut_vec !== model_vec()) begin
                    errors++;
                    $display("FAIL random_model t=%0d: got %h expected %h", t, dut_vec, model_vec());
                end
            end
        end
    endtask

    initial begin
        enable    = 1'b0;
        lead_lag  = '0;
        enable4   = 1'b0;
        lead_lag4 = '0;
        reset_n   = 1'b0;
        @(negedge ref_clk);
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_lead();
        test_lock_track();
        test_disable();
        test_reset_mid_track();
        test_nch4();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
